// File: rtl/md_arbiter.sv
// md_arbiter
//   Round-robin arbiter/sequencer that shares one iterative multiply/divide
//   unit between NREQ requesters. One operation is in flight at a time: it is
//   accepted from the winning requester, issued to the unit, and its result is
//   held until the owning requester takes it. Divide/remainder by zero is
//   answered directly without touching the unit.
//
// Handshakes: every valid/ready pair transfers on a rising clock edge where
//   both are high. A valid, once raised, stays high with its payload stable
//   until that edge; ready may change freely.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   rq_*                  per-requester request channel (requester i in slice i)
//   rs_valid / rs_ready   per-requester response channel
//   rs_result             shared response data, qualified by rs_valid
//   md_req_*              request channel to the multiply/divide unit
//   md_resp_valid/result  response from the multiply/divide unit
//
// The FSM register `state` and round-robin pointer `ptr` are plain named
// signals so that checkers can bind to them directly.
module md_arbiter #(
    parameter int NREQ = 2,
    parameter int XLEN = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      rq_valid,
    output logic [NREQ-1:0]      rq_ready,
    input  logic [2*NREQ-1:0]    rq_op,
    input  logic [2*NREQ-1:0]    rq_out_sel,
    input  logic [NREQ-1:0]      rq_in_1_signed,
    input  logic [NREQ-1:0]      rq_in_2_signed,
    input  logic [XLEN*NREQ-1:0] rq_in_1,
    input  logic [XLEN*NREQ-1:0] rq_in_2,
    output logic [NREQ-1:0]      rs_valid,
    input  logic [NREQ-1:0]      rs_ready,
    output logic [XLEN-1:0]      rs_result,
    output logic                 md_req_valid,
    input  logic                 md_req_ready,
    output logic [1:0]           md_req_op,
    output logic [1:0]           md_req_out_sel,
    output logic                 md_req_in_1_signed,
    output logic                 md_req_in_2_signed,
    output logic [XLEN-1:0]      md_req_in_1,
    output logic [XLEN-1:0]      md_req_in_2,
    input  logic                 md_resp_valid,
    input  logic [XLEN-1:0]      md_resp_result
);

    localparam logic [1:0] MD_OP_DIV = 2'd1;
    localparam logic [1:0] MD_OP_REM = 2'd2;

    localparam int IDX_W = (NREQ > 2) ? 2 : 1;
    localparam int SW    = IDX_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   owner;

    logic               grant_found;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   cand;
    logic [SW-1:0]      sum;

    logic [1:0]         sel_op;
    logic [1:0]         sel_out_sel;
    logic               sel_in_1_signed;
    logic               sel_in_2_signed;
    logic [XLEN-1:0]    sel_in_1;
    logic [XLEN-1:0]    sel_in_2;
    logic               sel_dbz;

    // Search starts at the pointer and wraps, so the requester just served
    // becomes lowest priority on the next round.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        sum         = '0;
        cand        = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum = {1'b0, ptr} + SW'(i);
            if (sum >= SW'(NREQ)) begin
                sum = sum - SW'(NREQ);
            end
            cand = sum[IDX_W-1:0];
            if (!grant_found && rq_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Payload of the current winner.
    always_comb begin
        sel_op          = '0;
        sel_out_sel     = '0;
        sel_in_1_signed = 1'b0;
        sel_in_2_signed = 1'b0;
        sel_in_1        = '0;
        sel_in_2        = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                sel_op          = rq_op[i*2 +: 2];
                sel_out_sel     = rq_out_sel[i*2 +: 2];
                sel_in_1_signed = rq_in_1_signed[i];
                sel_in_2_signed = rq_in_2_signed[i];
                sel_in_1        = rq_in_1[i*XLEN +: XLEN];
                sel_in_2        = rq_in_2[i*XLEN +: XLEN];
            end
        end
    end

    assign sel_dbz = ((sel_op == MD_OP_DIV) || (sel_op == MD_OP_REM)) &&
                     (sel_in_2 == '0);

    // Grant is combinational so the op is taken on the same edge it is offered.
    always_comb begin
        rq_ready = '0;
        if ((state == IDLE) && grant_found) begin
            rq_ready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state              <= IDLE;
            ptr                <= '0;
            owner              <= '0;
            rs_valid           <= '0;
            rs_result          <= '0;
            md_req_valid       <= 1'b0;
            md_req_op          <= '0;
            md_req_out_sel     <= '0;
            md_req_in_1_signed <= 1'b0;
            md_req_in_2_signed <= 1'b0;
            md_req_in_1        <= '0;
            md_req_in_2        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        owner              <= grant_idx;
                        ptr                <= (grant_idx == IDX_W'(NREQ-1)) ?
                                              '0 : grant_idx + IDX_W'(1);
                        md_req_op          <= sel_op;
                        md_req_out_sel     <= sel_out_sel;
                        md_req_in_1_signed <= sel_in_1_signed;
                        md_req_in_2_signed <= sel_in_2_signed;
                        md_req_in_1        <= sel_in_1;
                        md_req_in_2        <= sel_in_2;
                        if (sel_dbz) begin
                            // Division by zero answered locally: quotient is
                            // all ones, remainder is the dividend.
                            rs_result <= (sel_op == MD_OP_DIV) ? '1 : sel_in_1;
                            rs_valid  <= NREQ'(1) << grant_idx;
                            state     <= RESP;
                        end else begin
                            md_req_valid <= 1'b1;
                            state        <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (md_req_ready) begin
                        md_req_valid <= 1'b0;
                        state        <= BUSY;
                    end
                end
                BUSY: begin
                    if (md_resp_valid) begin
                        rs_result <= md_resp_result;
                        rs_valid  <= NREQ'(1) << owner;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    // Only the owner's ready completes the response.
                    if (rs_ready[owner]) begin
                        rs_valid <= '0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_arbiter.sv
// Bench for md_arbiter: a behavioural multiply/divide unit, a scoreboard fed
// at request acceptance, and a negedge monitor that checks arbitration,
// unit-side traffic and responses.
module tb_md_arbiter;

  localparam int NREQ = 2;
  localparam int XLEN = 32;
  localparam int CW   = 72;

  localparam logic [1:0] OP_MUL = 2'd0;
  localparam logic [1:0] OP_DIV = 2'd1;
  localparam logic [1:0] OP_REM = 2'd2;
  localparam logic [1:0] OUT_LO = 2'd0;
  localparam logic [1:0] OUT_HI = 2'd1;
  localparam logic [1:0] OUT_REM = 2'd2;

  logic                 clk;
  logic                 reset_n;
  logic [NREQ-1:0]      rq_valid;
  logic [NREQ-1:0]      rq_ready;
  logic [2*NREQ-1:0]    rq_op;
  logic [2*NREQ-1:0]    rq_out_sel;
  logic [NREQ-1:0]      rq_in_1_signed;
  logic [NREQ-1:0]      rq_in_2_signed;
  logic [XLEN*NREQ-1:0] rq_in_1;
  logic [XLEN*NREQ-1:0] rq_in_2;
  logic [NREQ-1:0]      rs_valid;
  logic [NREQ-1:0]      rs_ready;
  logic [XLEN-1:0]      rs_result;
  logic                 md_req_valid;
  logic                 md_req_ready;
  logic [1:0]           md_req_op;
  logic [1:0]           md_req_out_sel;
  logic                 md_req_in_1_signed;
  logic                 md_req_in_2_signed;
  logic [XLEN-1:0]      md_req_in_1;
  logic [XLEN-1:0]      md_req_in_2;
  logic                 md_resp_valid;
  logic [XLEN-1:0]      md_resp_result;

  md_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .rq_valid           (rq_valid),
    .rq_ready           (rq_ready),
    .rq_op              (rq_op),
    .rq_out_sel         (rq_out_sel),
    .rq_in_1_signed     (rq_in_1_signed),
    .rq_in_2_signed     (rq_in_2_signed),
    .rq_in_1            (rq_in_1),
    .rq_in_2            (rq_in_2),
    .rs_valid           (rs_valid),
    .rs_ready           (rs_ready),
    .rs_result          (rs_result),
    .md_req_valid       (md_req_valid),
    .md_req_ready       (md_req_ready),
    .md_req_op          (md_req_op),
    .md_req_out_sel     (md_req_out_sel),
    .md_req_in_1_signed (md_req_in_1_signed),
    .md_req_in_2_signed (md_req_in_2_signed),
    .md_req_in_1        (md_req_in_1),
    .md_req_in_2        (md_req_in_2),
    .md_resp_valid      (md_resp_valid),
    .md_resp_result     (md_resp_result)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;

  logic [XLEN-1:0] exp_q[$];
  int              own_q[$];
  logic [69:0]     iss_q[$];
  int              grant_log[$];

  logic            outstanding;
  int              m_ptr;
  int              c;
  int              win;
  logic [69:0]     f;
  logic [69:0]     cur_f;
  logic [69:0]     prev_f;
  logic [XLEN-1:0] e;
  logic [NREQ-1:0] oh;
  logic            rs_hs;
  logic            md_prev_stall;
  logic            iss_chk;
  logic            dbz_chk;
  logic            dbz;
  int              dbz_own;
  int              md_hs_cnt = 0;
  logic [XLEN-1:0] last_res;

  // knobs owned by the main sequence, read by the unit model
  logic            hold_ready;
  int              lat_min;
  int              lat_max;

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference arithmetic of the multiply/divide unit.
  function automatic logic [XLEN-1:0] unit_calc(input logic [1:0] op, input logic [1:0] sel,
                                                input logic s1, input logic s2,
                                                input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic signed [127:0] ea;
    logic signed [127:0] eb;
    logic signed [127:0] r;
    ea = s1 ? {{96{a[31]}}, a} : {96'b0, a};
    eb = s2 ? {{96{b[31]}}, b} : {96'b0, b};
    if (op == OP_MUL) begin
      r = ea * eb;
      return (sel == OUT_HI) ? r[63:32] : r[31:0];
    end
    if (eb == 0) return (op == OP_DIV) ? 32'hFFFF_FFFF : a;
    r = (op == OP_DIV) ? (ea / eb) : (ea % eb);
    return r[31:0];
  endfunction

  // ---------------- behavioural multiply/divide unit ----------------
  initial begin
    logic            hs;
    logic            u_busy;
    int              u_cnt;
    logic [XLEN-1:0] u_res;
    logic [XLEN-1:0] res;
    md_req_ready   = 1'b0;
    md_resp_valid  = 1'b0;
    md_resp_result = '0;
    u_busy = 1'b0;
    u_cnt  = 0;
    u_res  = '0;
    res    = '0;
    forever begin
      @(negedge clk);
      hs = md_req_valid && md_req_ready;
      if (hs) res = unit_calc(md_req_op, md_req_out_sel, md_req_in_1_signed,
                              md_req_in_2_signed, md_req_in_1, md_req_in_2);
      @(posedge clk);
      #1;
      md_resp_valid  = 1'b0;
      md_resp_result = $urandom;
      if (hs) begin
        u_busy = 1'b1;
        u_cnt  = $urandom_range(lat_min, lat_max);
        u_res  = res;
      end else if (u_busy) begin
        if (u_cnt == 0) begin
          md_resp_valid  = 1'b1;
          md_resp_result = u_res;
          u_busy         = 1'b0;
        end else begin
          u_cnt--;
        end
      end
      md_req_ready = !u_busy && !hold_ready && ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!reset_n) begin
      outstanding   = 1'b0;
      m_ptr         = 0;
      exp_q.delete();
      own_q.delete();
      iss_q.delete();
      grant_log.delete();
      md_prev_stall = 1'b0;
      iss_chk       = 1'b0;
      dbz_chk       = 1'b0;
    end else begin
      if (iss_chk) begin
        chk("issue_latency", CW'(md_req_valid), CW'(1'b1));
        iss_chk = 1'b0;
      end
      if (dbz_chk) begin
        oh = '0;
        oh[dbz_own] = 1'b1;
        chk("dbz_latency", CW'({md_req_valid, rs_valid}), CW'({1'b0, oh}));
        dbz_chk = 1'b0;
      end

      // unit-side request channel
      cur_f = {md_req_op, md_req_out_sel, md_req_in_1_signed, md_req_in_2_signed,
               md_req_in_1, md_req_in_2};
      if (md_prev_stall) chk("md_stable", CW'({md_req_valid, cur_f}), CW'({1'b1, prev_f}));
      md_prev_stall = md_req_valid && !md_req_ready;
      prev_f        = cur_f;
      if (iss_q.size() == 0) begin
        chk("md_idle", CW'(md_req_valid), CW'(1'b0));
      end else if (md_req_valid && md_req_ready) begin
        chk("md_fields", CW'(cur_f), CW'(iss_q[0]));
        void'(iss_q.pop_front());
        md_hs_cnt++;
      end

      // response channel
      rs_hs = 1'b0;
      if (exp_q.size() == 0) begin
        chk("rs_idle", CW'(rs_valid), CW'(0));
      end else if (rs_valid != '0) begin
        oh = '0;
        oh[own_q[0]] = 1'b1;
        chk("rs_valid", CW'(rs_valid), CW'(oh));
        chk("rs_result", CW'(rs_result), CW'(exp_q[0]));
        if (rs_ready[own_q[0]] && rs_valid[own_q[0]]) begin
          last_res = rs_result;
          void'(exp_q.pop_front());
          void'(own_q.pop_front());
          rs_hs = 1'b1;
        end
      end

      // arbitration: first valid at or after the pointer, only when idle
      win = -1;
      if (!outstanding) begin
        for (int k = 0; k < NREQ; k++) begin
          c = (m_ptr + k) % NREQ;
          if (win < 0 && rq_valid[c]) win = c;
        end
      end
      oh = '0;
      if (win >= 0) oh[win] = 1'b1;
      chk("rq_ready", CW'(rq_ready), CW'(oh));
      if (win >= 0) begin
        f = {rq_op[win*2 +: 2], rq_out_sel[win*2 +: 2], rq_in_1_signed[win],
             rq_in_2_signed[win], rq_in_1[win*XLEN +: XLEN], rq_in_2[win*XLEN +: XLEN]};
        dbz = ((f[69:68] == OP_DIV) || (f[69:68] == OP_REM)) && (f[31:0] == 0);
        if (dbz) e = (f[69:68] == OP_DIV) ? 32'hFFFF_FFFF : f[63:32];
        else     e = unit_calc(f[69:68], f[67:66], f[65], f[64], f[63:32], f[31:0]);
        exp_q.push_back(e);
        own_q.push_back(win);
        grant_log.push_back(win);
        if (dbz) begin
          dbz_chk = 1'b1;
          dbz_own = win;
        end else begin
          iss_q.push_back(f);
          iss_chk = 1'b1;
        end
        outstanding = 1'b1;
        m_ptr = (win + 1) % NREQ;
      end
      if (rs_hs) outstanding = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    logic [NREQ-1:0] acc;
    @(negedge clk);
    acc = rq_valid & rq_ready;
    @(posedge clk);
    #1;
    rq_valid = rq_valid & ~acc;
  endtask

  task automatic gen_req(input int i, input logic [1:0] op, input logic [1:0] sel,
                         input logic s1, input logic s2,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    rq_op[i*2 +: 2]          = op;
    rq_out_sel[i*2 +: 2]     = sel;
    rq_in_1_signed[i]        = s1;
    rq_in_2_signed[i]        = s2;
    rq_in_1[i*XLEN +: XLEN]  = a;
    rq_in_2[i*XLEN +: XLEN]  = b;
    rq_valid[i]              = 1'b1;
  endtask

  task automatic rand_req(input int i);
    logic [1:0]      op;
    logic [1:0]      sel;
    logic [XLEN-1:0] b;
    op  = 2'($urandom_range(0, 2));
    sel = (op == OP_MUL) ? 2'($urandom_range(0, 1)) : ((op == OP_DIV) ? OUT_LO : OUT_REM);
    case ($urandom_range(0, 4))
      0:       b = '0;
      1:       b = 32'($urandom_range(1, 9));
      default: b = $urandom;
    endcase
    gen_req(i, op, sel, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, b);
  endtask

  task automatic wait_idle(input string name);
    logic done;
    done = 1'b0;
    for (int n = 0; n < 400 && !done; n++) begin
      if (rq_valid == '0 && exp_q.size() == 0) done = 1'b1;
      else step();
    end
    if (!done) chk({name, "_timeout"}, CW'(0), CW'(1));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic done;
    reset_n        = 1'b0;
    rq_valid       = '0;
    rq_op          = '0;
    rq_out_sel     = '0;
    rq_in_1_signed = '0;
    rq_in_2_signed = '0;
    rq_in_1        = '0;
    rq_in_2        = '0;
    rs_ready       = '1;
    hold_ready     = 1'b0;
    lat_min        = 0;
    lat_max        = 4;

    repeat (3) @(negedge clk);
    chk("reset_out", CW'({rq_ready, rs_valid, md_req_valid, rs_result}), CW'(0));
    chk("reset_md", CW'({md_req_op, md_req_out_sel, md_req_in_1_signed, md_req_in_2_signed,
                         md_req_in_1, md_req_in_2}), CW'(0));
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // round robin with both requesters held valid
    rand_req(0);
    rand_req(1);
    done = 1'b0;
    for (int n = 0; n < 400 && !done; n++) begin
      step();
      if (grant_log.size() >= 4) done = 1'b1;
      else for (int i = 0; i < NREQ; i++) if (!rq_valid[i]) rand_req(i);
    end
    if (!done) chk("rr_timeout", CW'(0), CW'(1));
    else begin
      chk("rr_order", CW'({grant_log[0][1:0], grant_log[1][1:0], grant_log[2][1:0],
                           grant_log[3][1:0]}), CW'(8'b00_01_00_01));
    end
    wait_idle("rr");

    // single signed divide
    gen_req(0, OP_DIV, OUT_LO, 1'b1, 1'b1, -32'sd7, 32'd2);
    wait_idle("div");
    chk("div_result", CW'(last_res), CW'(32'hFFFF_FFFD));

    // divide and remainder by zero
    gen_req(1, OP_DIV, OUT_LO, 1'b0, 1'b0, 32'd100, 32'd0);
    wait_idle("dbz_div");
    chk("dbz_div_result", CW'(last_res), CW'(32'hFFFF_FFFF));
    gen_req(1, OP_REM, OUT_REM, 1'b1, 1'b1, 32'd100, 32'd0);
    wait_idle("dbz_rem");
    chk("dbz_rem_result", CW'(last_res), CW'(32'd100));

    // unit and response backpressure
    hold_ready = 1'b1;
    rs_ready   = '0;
    gen_req(0, OP_MUL, OUT_HI, 1'b1, 1'b0, 32'h8000_0003, 32'h1234_5678);
    step();
    for (int n = 0; n < 5; n++) begin
      step();
      chk("bp_md_valid", CW'(md_req_valid), CW'(1'b1));
    end
    hold_ready = 1'b0;
    done = 1'b0;
    for (int n = 0; n < 100 && !done; n++) begin
      if (rs_valid != '0) done = 1'b1;
      else step();
    end
    if (!done) chk("bp_resp_timeout", CW'(0), CW'(1));
    gen_req(1, OP_MUL, OUT_LO, 1'b0, 1'b0, 32'd6, 32'd7);
    for (int n = 0; n < 3; n++) begin
      step();
      chk("bp_rs_hold", CW'({rq_ready, rs_valid}), CW'({2'b00, 2'b01}));
    end
    rs_ready = '1;
    wait_idle("bp");

    // reset while the unit is working
    lat_min = 15;
    lat_max = 15;
    gen_req(1, OP_MUL, OUT_LO, 1'b0, 1'b0, 32'd3, 32'd5);
    done = 1'b0;
    begin
      int n0;
      n0 = md_hs_cnt;
      for (int n = 0; n < 100 && !done; n++) begin
        if (md_hs_cnt > n0) done = 1'b1;
        else step();
      end
    end
    if (!done) chk("rst_issue_timeout", CW'(0), CW'(1));
    step();
    step();
    reset_n  = 1'b0;
    rq_valid = '0;
    @(negedge clk);
    chk("rst_mid_out", CW'({rq_ready, rs_valid, md_req_valid, rs_result}), CW'(0));
    chk("rst_mid_md", CW'({md_req_op, md_req_out_sel, md_req_in_1_signed, md_req_in_2_signed,
                           md_req_in_1, md_req_in_2}), CW'(0));
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    lat_min = 0;
    lat_max = 4;
    for (int n = 0; n < 25; n++) step();
    gen_req(1, OP_MUL, OUT_LO, 1'b0, 1'b0, 32'd9, 32'd9);
    gen_req(0, OP_MUL, OUT_LO, 1'b0, 1'b0, 32'd4, 32'd4);
    done = 1'b0;
    for (int n = 0; n < 50 && !done; n++) begin
      if (grant_log.size() >= 1) done = 1'b1;
      else step();
    end
    if (!done) chk("rst_ptr_timeout", CW'(0), CW'(1));
    else chk("rst_ptr_first", CW'(grant_log[0]), CW'(0));
    wait_idle("rst");

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!rq_valid[i] && $urandom_range(0, 2) == 0) rand_req(i);
      end
      rs_ready = NREQ'($urandom);
      step();
    end
    rs_ready = '1;
    wait_idle("rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
